// File: rtl/alarm_clock_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_clock_core_if
//  Description : Bundle of every non-clock, non-reset signal of the alarm
//                clock core. The master side (keyboard time entry) drives
//                the set/alarm/control inputs; the slave side (the core)
//                returns the time, display hour and ring status.
//  Ports       : none (signals reached through the master/slave modports)
//  Revision    : 1.0 - initial release
// ============================================================================
interface alarm_clock_core_if;

    // control
    logic       run_en;
    logic       mode_12h;
    logic       stop;
    logic       snooze;

    // time load
    logic       set_en;
    logic [5:0] hour_set;
    logic [5:0] minute_set;
    logic [5:0] second_set;

    // alarm slot write
    logic       alarm_wr_en;
    logic [2:0] alarm_idx;
    logic [5:0] alarm_hour;
    logic [5:0] alarm_minute;
    logic       alarm_on;

    // status back to the display logic
    logic [5:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [5:0] disp_hour;
    logic       pm;
    logic       tick;
    logic       ringing;
    logic       snoozing;
    logic [2:0] ring_idx;
    logic       cmd_err;

    modport master (
        output run_en, mode_12h, stop, snooze,
        output set_en, hour_set, minute_set, second_set,
        output alarm_wr_en, alarm_idx, alarm_hour, alarm_minute, alarm_on,
        input  hour, minute, second, disp_hour, pm, tick,
        input  ringing, snoozing, ring_idx, cmd_err
    );

    modport slave (
        input  run_en, mode_12h, stop, snooze,
        input  set_en, hour_set, minute_set, second_set,
        input  alarm_wr_en, alarm_idx, alarm_hour, alarm_minute, alarm_on,
        output hour, minute, second, disp_hour, pm, tick,
        output ringing, snoozing, ring_idx, cmd_err
    );

endinterface
`default_nettype wire

// File: rtl/alarm_clock_core.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_clock_core
//  Description : One-second prescaler, 24-hour hh:mm:ss counter with
//                validated loading, ALARMS alarm slots and a ring/snooze
//                state machine.
//  Ports       : CLK_50   - system clock, rising edge
//                reset_en - synchronous active-high reset
//                bus      - alarm_clock_core_if.slave (time entry in,
//                           time/display/ring status out)
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_clock_core #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int ALARMS         = 2,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300
) (
    input  wire                  CLK_50,
    input  wire                  reset_en,
    alarm_clock_core_if.slave    bus
);

    localparam int c_PW = $clog2(CLK_HZ);
    localparam int c_RW = $clog2(RING_SECONDS + 1);
    localparam int c_SW = $clog2(SNOOZE_SECONDS + 1);

    localparam logic [c_PW-1:0] c_PMAX     = c_PW'(CLK_HZ - 1);
    localparam logic [c_RW-1:0] c_RING_END = c_RW'(RING_SECONDS);
    localparam logic [c_SW-1:0] c_SNZ_END  = c_SW'(SNOOZE_SECONDS);
    localparam logic [3:0]      c_NSLOTS   = 4'(ALARMS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RING   = 2'd1;
    localparam logic [1:0] S_SNOOZE = 2'd2;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [c_PW-1:0] r_presc;
    logic [5:0]      r_hour, r_min, r_sec;
    logic [5:0]      r_disp_hour;
    logic            r_pm;
    logic            r_tick;
    logic            r_cmd_err;
    logic [1:0]      r_state;
    logic [c_RW-1:0] r_ring_cnt;
    logic [c_SW-1:0] r_snz_cnt;
    logic [2:0]      r_ring_idx;

    logic [5:0]      r_al_hour [ALARMS];
    logic [5:0]      r_al_min  [ALARMS];
    logic            r_al_en   [ALARMS];

    // ------------------------------------------------------------------
    // Command validation
    // ------------------------------------------------------------------
    logic w_set_valid, w_set_ok, w_wr_ok, w_dis_ring;

    assign w_set_valid = (bus.hour_set <= 6'd23) && (bus.minute_set <= 6'd59)
                      && (bus.second_set <= 6'd59);
    assign w_set_ok    = bus.set_en && w_set_valid;
    assign w_wr_ok     = bus.alarm_wr_en && ({1'b0, bus.alarm_idx} < c_NSLOTS)
                      && (bus.alarm_hour <= 6'd23) && (bus.alarm_minute <= 6'd59);
    // Disabling the slot that is currently ringing/snoozing cancels it.
    assign w_dis_ring  = w_wr_ok && !bus.alarm_on && (bus.alarm_idx == r_ring_idx);

    // ------------------------------------------------------------------
    // Prescaler and time next-state
    // ------------------------------------------------------------------
    logic            w_wrap, w_adv;
    logic [c_PW-1:0] w_nxt_presc;
    logic [5:0]      w_nxt_hour, w_nxt_min, w_nxt_sec;
    logic [5:0]      w_nxt_disp;

    assign w_wrap = bus.run_en && (r_presc == c_PMAX);
    // A valid load swallows a coincident wrap: no advance, no tick.
    assign w_adv  = w_wrap && !w_set_ok;

    always_comb begin
        w_nxt_presc = r_presc;
        w_nxt_hour  = r_hour;
        w_nxt_min   = r_min;
        w_nxt_sec   = r_sec;
        if (w_set_ok) begin
            w_nxt_presc = '0;
            w_nxt_hour  = bus.hour_set;
            w_nxt_min   = bus.minute_set;
            w_nxt_sec   = bus.second_set;
        end else if (bus.run_en) begin
            if (w_wrap) begin
                w_nxt_presc = '0;
                if (r_sec == 6'd59) begin
                    w_nxt_sec = 6'd0;
                    if (r_min == 6'd59) begin
                        w_nxt_min  = 6'd0;
                        w_nxt_hour = (r_hour == 6'd23) ? 6'd0 : r_hour + 6'd1;
                    end else begin
                        w_nxt_min = r_min + 6'd1;
                    end
                end else begin
                    w_nxt_sec = r_sec + 6'd1;
                end
            end else begin
                w_nxt_presc = r_presc + 1'b1;
            end
        end
    end

    // Display hour follows the next-state hour so it moves with hour.
    always_comb begin
        w_nxt_disp = w_nxt_hour;
        if (bus.mode_12h) begin
            if (w_nxt_hour == 6'd0)
                w_nxt_disp = 6'd12;
            else if (w_nxt_hour > 6'd12)
                w_nxt_disp = w_nxt_hour - 6'd12;
        end
    end

    always_ff @(posedge CLK_50) begin
        if (reset_en) begin
            r_presc     <= '0;
            r_hour      <= 6'd0;
            r_min       <= 6'd0;
            r_sec       <= 6'd0;
            r_disp_hour <= bus.mode_12h ? 6'd12 : 6'd0;
            r_pm        <= 1'b0;
            r_tick      <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_presc     <= w_nxt_presc;
            r_hour      <= w_nxt_hour;
            r_min       <= w_nxt_min;
            r_sec       <= w_nxt_sec;
            r_disp_hour <= w_nxt_disp;
            r_pm        <= (w_nxt_hour >= 6'd12);
            r_tick      <= w_adv;
            r_cmd_err   <= (bus.set_en && !w_set_valid) || (bus.alarm_wr_en && !w_wr_ok);
        end
    end

    // ------------------------------------------------------------------
    // Alarm slots and match detection
    // ------------------------------------------------------------------
    logic [ALARMS-1:0] w_match;

    genvar gi;
    generate
        for (gi = 0; gi < ALARMS; gi++) begin : g_slot
            always_ff @(posedge CLK_50) begin
                if (reset_en) begin
                    r_al_hour[gi] <= 6'd0;
                    r_al_min[gi]  <= 6'd0;
                    r_al_en[gi]   <= 1'b0;
                end else if (w_wr_ok && (bus.alarm_idx == 3'(gi))) begin
                    r_al_hour[gi] <= bus.alarm_hour;
                    r_al_min[gi]  <= bus.alarm_minute;
                    r_al_en[gi]   <= bus.alarm_on;
                end
            end

            // Compared against the time being entered on this tick.
            assign w_match[gi] = w_adv && (w_nxt_sec == 6'd0) && r_al_en[gi]
                              && (r_al_hour[gi] == w_nxt_hour)
                              && (r_al_min[gi] == w_nxt_min);
        end
    endgenerate

    logic       w_match_any;
    logic [2:0] w_match_idx;

    // Scan downwards so the lowest matching slot is the one left standing.
    always_comb begin
        w_match_any = 1'b0;
        w_match_idx = 3'd0;
        for (int k = ALARMS - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                w_match_any = 1'b1;
                w_match_idx = 3'(k);
            end
        end
    end

    // ------------------------------------------------------------------
    // Ring / snooze state machine
    // ------------------------------------------------------------------
    logic [1:0]      w_state_nxt;
    logic [c_RW-1:0] w_ring_cnt_nxt, w_ring_inc;
    logic [c_SW-1:0] w_snz_cnt_nxt, w_snz_inc;
    logic [2:0]      w_ring_idx_nxt;

    assign w_ring_inc = r_ring_cnt + 1'b1;
    assign w_snz_inc  = r_snz_cnt + 1'b1;

    always_ff @(posedge CLK_50) begin
        if (reset_en) begin
            r_state    <= S_IDLE;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            r_ring_idx <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_ring_cnt <= w_ring_cnt_nxt;
            r_snz_cnt  <= w_snz_cnt_nxt;
            r_ring_idx <= w_ring_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ring_cnt_nxt = r_ring_cnt;
        w_snz_cnt_nxt  = r_snz_cnt;
        w_ring_idx_nxt = r_ring_idx;
        case (r_state)
            S_IDLE: begin
                if (w_match_any) begin
                    w_state_nxt    = S_RING;
                    w_ring_idx_nxt = w_match_idx;
                    w_ring_cnt_nxt = '0;
                end
            end
            S_RING: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.snooze) begin
                    w_state_nxt   = S_SNOOZE;
                    w_snz_cnt_nxt = '0;
                end else if (w_adv) begin
                    if (w_ring_inc == c_RING_END)
                        w_state_nxt = S_IDLE;
                    else
                        w_ring_cnt_nxt = w_ring_inc;
                end
            end
            S_SNOOZE: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_match_any) begin
                    w_state_nxt    = S_RING;
                    w_ring_idx_nxt = w_match_idx;
                    w_ring_cnt_nxt = '0;
                end else if (w_adv) begin
                    if (w_snz_inc == c_SNZ_END) begin
                        w_state_nxt    = S_RING;
                        w_ring_cnt_nxt = '0;
                    end else begin
                        w_snz_cnt_nxt = w_snz_inc;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_set_ok || w_dis_ring)
            w_state_nxt = S_IDLE;
    end

    // ------------------------------------------------------------------
    // Outputs (all sourced from registers)
    // ------------------------------------------------------------------
    assign bus.hour      = r_hour;
    assign bus.minute    = r_min;
    assign bus.second    = r_sec;
    assign bus.disp_hour = r_disp_hour;
    assign bus.pm        = r_pm;
    assign bus.tick      = r_tick;
    assign bus.cmd_err   = r_cmd_err;
    assign bus.ringing   = (r_state == S_RING);
    assign bus.snoozing  = (r_state == S_SNOOZE);
    assign bus.ring_idx  = r_ring_idx;

endmodule
`default_nettype wire

// File: tb/tb_alarm_clock_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_clock_core
//  Description : Directed self-checking bench for alarm_clock_core with a
//                4-cycle second, 3-second ring and 2-second snooze.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alarm_clock_core;

    localparam int c_CLK_HZ = 4;
    localparam int c_ALARMS = 2;
    localparam int c_RING   = 3;
    localparam int c_SNOOZE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alarm_clock_core_if acc_if ();

    alarm_clock_core #(
        .CLK_HZ         (c_CLK_HZ),
        .ALARMS         (c_ALARMS),
        .RING_SECONDS   (c_RING),
        .SNOOZE_SECONDS (c_SNOOZE)
    ) u_dut (
        .CLK_50   (clk),
        .reset_en (rst),
        .bus      (acc_if.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 2 * c_CLK_HZ + 2; i++) begin
            step();
            if (acc_if.tick) begin
                got = 1'b1;
                break;
            end
        end
        check_eq({tag, "_tick_seen"}, 32'(got), 32'd1);
    endtask

    task automatic set_time(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        acc_if.set_en     = 1'b1;
        acc_if.hour_set   = h;
        acc_if.minute_set = m;
        acc_if.second_set = s;
        step();
        acc_if.set_en     = 1'b0;
    endtask

    task automatic write_alarm(input logic [2:0] idx, input logic [5:0] h,
                               input logic [5:0] m, input logic on);
        acc_if.alarm_wr_en  = 1'b1;
        acc_if.alarm_idx    = idx;
        acc_if.alarm_hour   = h;
        acc_if.alarm_minute = m;
        acc_if.alarm_on     = on;
        step();
        acc_if.alarm_wr_en  = 1'b0;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check_eq({tag, "_hour"},   32'(acc_if.hour),   32'(h));
        check_eq({tag, "_minute"}, 32'(acc_if.minute), 32'(m));
        check_eq({tag, "_second"}, 32'(acc_if.second), 32'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        acc_if.run_en       = 1'b0;
        acc_if.mode_12h     = 1'b0;
        acc_if.stop         = 1'b0;
        acc_if.snooze       = 1'b0;
        acc_if.set_en       = 1'b0;
        acc_if.hour_set     = 6'd0;
        acc_if.minute_set   = 6'd0;
        acc_if.second_set   = 6'd0;
        acc_if.alarm_wr_en  = 1'b0;
        acc_if.alarm_idx    = 3'd0;
        acc_if.alarm_hour   = 6'd0;
        acc_if.alarm_minute = 6'd0;
        acc_if.alarm_on     = 1'b0;

        // ---- reset state ----
        rst = 1'b1;
        repeat (3) step();
        check_time("rst", 0, 0, 0);
        check_eq("rst_tick",      32'(acc_if.tick),      32'd0);
        check_eq("rst_ringing",   32'(acc_if.ringing),   32'd0);
        check_eq("rst_snoozing",  32'(acc_if.snoozing),  32'd0);
        check_eq("rst_cmd_err",   32'(acc_if.cmd_err),   32'd0);
        check_eq("rst_disp_hour", 32'(acc_if.disp_hour), 32'd0);
        check_eq("rst_pm",        32'(acc_if.pm),        32'd0);

        // ---- free run: tick on cycles 4, 8, 12 ----
        rst = 1'b0;
        acc_if.run_en = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            check_eq($sformatf("run_tick_c%0d", c), 32'(acc_if.tick), 32'((c % 4) == 0));
        end
        check_time("run12", 0, 0, 3);
        check_eq("run12_ringing", 32'(acc_if.ringing), 32'd0);
        check_eq("run12_cmd_err", 32'(acc_if.cmd_err), 32'd0);

        // ---- midnight wrap and 12-hour display ----
        set_time(6'd23, 6'd59, 6'd58);
        check_time("set_2359", 23, 59, 58);
        check_eq("set_2359_pm", 32'(acc_if.pm), 32'd1);
        wait_tick("wrap1");
        check_time("wrap1", 23, 59, 59);
        wait_tick("wrap2");
        check_time("wrap2", 0, 0, 0);
        acc_if.mode_12h = 1'b1;
        step();
        check_eq("h12_disp_midnight", 32'(acc_if.disp_hour), 32'd12);
        check_eq("h12_pm_midnight",   32'(acc_if.pm),        32'd0);
        set_time(6'd13, 6'd0, 6'd0);
        check_eq("h12_disp_13", 32'(acc_if.disp_hour), 32'd1);
        check_eq("h12_pm_13",   32'(acc_if.pm),        32'd1);
        check_eq("h12_hour_13", 32'(acc_if.hour),      32'd13);

        // ---- rejected commands ----
        set_time(6'd25, 6'd0, 6'd0);
        check_eq("bad_set_err",  32'(acc_if.cmd_err), 32'd1);
        check_eq("bad_set_hour", 32'(acc_if.hour),    32'd13);
        step();
        check_eq("bad_set_err_pulse", 32'(acc_if.cmd_err), 32'd0);
        write_alarm(3'd2, 6'd7, 6'd30, 1'b1);
        check_eq("bad_idx_err", 32'(acc_if.cmd_err), 32'd1);

        // ---- two slots at 07:30: slot 0 wins, auto-stop after 3 ticks ----
        write_alarm(3'd0, 6'd7, 6'd30, 1'b1);
        write_alarm(3'd1, 6'd7, 6'd30, 1'b1);
        set_time(6'd7, 6'd29, 6'd59);
        wait_tick("ring");
        check_time("ring", 7, 30, 0);
        check_eq("ring_on",  32'(acc_if.ringing),  32'd1);
        check_eq("ring_idx", 32'(acc_if.ring_idx), 32'd0);
        wait_tick("ring_t1");
        check_eq("ring_t1_on", 32'(acc_if.ringing), 32'd1);
        wait_tick("ring_t2");
        check_eq("ring_t2_on", 32'(acc_if.ringing), 32'd1);
        wait_tick("ring_t3");
        check_eq("ring_t3_off", 32'(acc_if.ringing), 32'd0);

        // ---- snooze, re-ring after 2 ticks, stop ----
        set_time(6'd7, 6'd29, 6'd59);
        wait_tick("snz_ring");
        check_eq("snz_ring_on", 32'(acc_if.ringing), 32'd1);
        acc_if.snooze = 1'b1;
        step();
        acc_if.snooze = 1'b0;
        check_eq("snz_snoozing", 32'(acc_if.snoozing), 32'd1);
        check_eq("snz_ringing",  32'(acc_if.ringing),  32'd0);
        wait_tick("snz_t1");
        check_eq("snz_t1_snoozing", 32'(acc_if.snoozing), 32'd1);
        wait_tick("snz_t2");
        check_eq("snz_t2_ringing",  32'(acc_if.ringing),  32'd1);
        check_eq("snz_t2_snoozing", 32'(acc_if.snoozing), 32'd0);
        acc_if.stop = 1'b1;
        step();
        acc_if.stop = 1'b0;
        check_eq("stop_ringing",  32'(acc_if.ringing),  32'd0);
        check_eq("stop_snoozing", 32'(acc_if.snoozing), 32'd0);

        // ---- slot 0 off: slot 1 rings; disabling slot 1 cancels it ----
        write_alarm(3'd0, 6'd7, 6'd30, 1'b0);
        set_time(6'd7, 6'd29, 6'd59);
        wait_tick("slot1");
        check_eq("slot1_ringing", 32'(acc_if.ringing),  32'd1);
        check_eq("slot1_idx",     32'(acc_if.ring_idx), 32'd1);
        write_alarm(3'd1, 6'd7, 6'd30, 1'b0);
        check_eq("slot1_cancel", 32'(acc_if.ringing), 32'd0);

        // ---- set coincident with a prescaler wrap ----
        wait_tick("coin");
        repeat (3) step();
        set_time(6'd10, 6'd20, 6'd30);
        check_time("coin", 10, 20, 30);
        check_eq("coin_tick", 32'(acc_if.tick), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            step();
            check_eq($sformatf("coin_gap_c%0d", c), 32'(acc_if.tick), 32'd0);
        end
        step();
        check_eq("coin_next_tick", 32'(acc_if.tick),   32'd1);
        check_eq("coin_next_sec",  32'(acc_if.second), 32'd31);

        // ---- reset in the middle of a ring ----
        write_alarm(3'd1, 6'd7, 6'd30, 1'b1);
        set_time(6'd7, 6'd29, 6'd59);
        wait_tick("rst_ring");
        check_eq("rst_ring_on",  32'(acc_if.ringing),  32'd1);
        check_eq("rst_ring_idx", 32'(acc_if.ring_idx), 32'd1);
        rst = 1'b1;
        step();
        check_time("mid_rst", 0, 0, 0);
        check_eq("mid_rst_ringing",   32'(acc_if.ringing),   32'd0);
        check_eq("mid_rst_snoozing",  32'(acc_if.snoozing),  32'd0);
        check_eq("mid_rst_idx",       32'(acc_if.ring_idx),  32'd0);
        check_eq("mid_rst_tick",      32'(acc_if.tick),      32'd0);
        check_eq("mid_rst_pm",        32'(acc_if.pm),        32'd0);
        check_eq("mid_rst_disp_hour", 32'(acc_if.disp_hour), 32'd12);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
